addsub_pipe: RTL

- Parametrised, 2-stage pipelined unsigned adder/subtractor with valid/ready handshakes on input and output.
- Supersedes the fixed 5-bit combinational subtractor for grid-coordinate and score arithmetic.
- Adds four modes (add, subtract, saturating subtract, modular wrap), status flags and backpressure.
- Sits between the snake movement/score logic and the state registers that consume results.

---
 rtl/addsub_pipe_if.sv | 33 +++
 rtl/addsub_pipe.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe_if.sv
// -----------------------------------------------------------------------------
// addsub_pipe_if
// Handshake bundle for the pipelined adder/subtractor.
//   in_valid / in_ready   : operation transfer (A, B, mode) into the block
//   out_valid / out_ready : result transfer (D, flag, zero, overflow) out
// master : the side that issues operations and consumes results
// slave  : the arithmetic block itself
// -----------------------------------------------------------------------------
interface addsub_pipe_if #(
    parameter int WIDTH = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             flag;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, A, B, mode, out_ready,
        input  in_ready, out_valid, D, flag, zero, overflow
    );

    modport slave (
        input  in_valid, A, B, mode, out_ready,
        output in_ready, out_valid, D, flag, zero, overflow
    );
endinterface

// File: rtl/addsub_pipe.sv
// -----------------------------------------------------------------------------
// addsub_pipe
// Two-stage pipelined unsigned adder/subtractor with valid/ready on both sides.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; empties the pipeline
//   bus   : addsub_pipe_if.slave (operation in, result + status flags out)
// Modes: 00 ADD, 01 SUB, 10 SSUB (saturate at 0), 11 WRAP (modulo MODULUS,
// B taken as two's complement). Stage 1 holds the low partial sum and the
// carry into the high half; stage 2 finishes the sum, post-processes per
// mode and is the output register. Capacity is two operations.
// -----------------------------------------------------------------------------
module addsub_pipe #(
    parameter int WIDTH   = 5,
    parameter int MODULUS = 20
) (
    input  logic         clk,
    input  logic         reset,
    addsub_pipe_if.slave bus
);
    localparam int LO = WIDTH / 2;
    localparam int HI = WIDTH - LO;

    localparam logic [WIDTH+1:0] MOD_EXT = (WIDTH + 2)'(MODULUS);
    localparam logic [WIDTH+1:0] TWO_W   = {2'b01, {WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_SUB  = 2'b01,
        MODE_SSUB = 2'b10,
        MODE_WRAP = 2'b11
    } mode_e;

    // ---------------- flow control ----------------
    logic s1_valid;
    logic s2_valid;
    logic s2_load;   // output register may take a new value this cycle
    logic s1_take;   // stage 1 may take a new value this cycle

    assign s2_load      = !s2_valid || bus.out_ready;
    assign s1_take      = !s1_valid || s2_load;
    assign bus.in_ready = !reset && s1_take;

    // ---------------- stage 1: low half ----------------
    mode_e            in_mode;
    logic             sub_op;
    logic [WIDTH-1:0] b_eff;
    logic [LO:0]      lo_sum;

    // NOTE: every always_comb output gets a value before any branch, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        in_mode = mode_e'(bus.mode);
        sub_op  = (in_mode == MODE_SUB) || (in_mode == MODE_SSUB);
        b_eff   = sub_op ? ~bus.B : bus.B;
        lo_sum  = {1'b0, bus.A[LO-1:0]} + {1'b0, b_eff[LO-1:0]}
                + {{LO{1'b0}}, sub_op};
    end

    logic [LO-1:0] s1_lo;
    logic          s1_mid_carry;
    logic [HI-1:0] s1_a_hi;
    logic [HI-1:0] s1_b_hi;   // already inverted for SUB/SSUB
    mode_e         s1_mode;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (s1_take) begin
            s1_valid <= bus.in_valid;
        end
    end

    // NOTE: payload registers carry no reset; they are only ever observed
    // behind a valid bit, which is reset.
    always_ff @(posedge clk) begin
        if (s1_take && bus.in_valid) begin
            s1_lo        <= lo_sum[LO-1:0];
            s1_mid_carry <= lo_sum[LO];
            s1_a_hi      <= bus.A[WIDTH-1:LO];
            s1_b_hi      <= b_eff[WIDTH-1:LO];
            s1_mode      <= in_mode;
        end
    end

    // ---------------- stage 2: high half + mode post-processing ----------------
    logic [HI:0]      hi_sum;
    logic [WIDTH:0]   raw;
    logic             carry;
    logic             a_sign;
    logic             b_sign;
    logic             d_sign;
    logic [WIDTH+1:0] wrap_s;     // A + sign_extend(B), two's complement
    logic             wrap_neg;
    logic             wrap_hi;
    logic [WIDTH+1:0] wrap_fix;
    logic [WIDTH-1:0] d_next;
    logic             flag_next;
    logic             ovf_next;

    always_comb begin
        hi_sum   = {1'b0, s1_a_hi} + {1'b0, s1_b_hi} + {{HI{1'b0}}, s1_mid_carry};
        raw      = {hi_sum, s1_lo};
        carry    = raw[WIDTH];
        a_sign   = s1_a_hi[HI-1];
        b_sign   = s1_b_hi[HI-1];
        d_sign   = raw[WIDTH-1];
        // A negative B was added as its unsigned image, i.e. 2^WIDTH too much.
        wrap_s   = {1'b0, raw} - (b_sign ? TWO_W : '0);
        wrap_neg = wrap_s[WIDTH+1];
        wrap_hi  = !wrap_neg && (wrap_s >= MOD_EXT);
        wrap_fix = wrap_s;
        if (wrap_neg) begin
            wrap_fix = wrap_s + MOD_EXT;
        end else if (wrap_hi) begin
            wrap_fix = wrap_s - MOD_EXT;
        end

        d_next    = raw[WIDTH-1:0];
        flag_next = 1'b0;
        ovf_next  = 1'b0;
        unique case (s1_mode)
            MODE_ADD, MODE_SUB: begin
                // With B already inverted for SUB, the signed-overflow rule is
                // the same for both: equal operand signs, differing result sign.
                flag_next = (s1_mode == MODE_ADD) ? carry : !carry;
                ovf_next  = (a_sign == b_sign) && (d_sign != a_sign);
            end
            MODE_SSUB: begin
                flag_next = !carry;
                d_next    = carry ? raw[WIDTH-1:0] : '0;
            end
            MODE_WRAP: begin
                flag_next = wrap_neg || wrap_hi;
                d_next    = wrap_fix[WIDTH-1:0];
            end
        endcase
    end

    logic [WIDTH-1:0] d_q;
    logic             flag_q;
    logic             zero_q;
    logic             ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            d_q      <= '0;
            flag_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                d_q    <= d_next;
                flag_q <= flag_next;
                zero_q <= (d_next == '0);
                ovf_q  <= ovf_next;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.D         = d_q;
    assign bus.flag      = flag_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
endmodule
